host_seq: RTL and testbench

- Upstream command sequencer feeding the accelerator's 64-bit AXI-Lite slave port.
- Converts a simple command stream (WRITE / READ / POLL) from host firmware or a DMA front-end into single-beat AXI transactions on the slave port.
- Returns one response per command.
- POLL re-reads a status address until a masked match is seen (e.g. waiting for the run-busy bit to clear), removing polling traffic from the host.

---
 rtl/host_seq.sv | 219 +++++++++++++++++++++
 tb/tb_host_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_seq.sv
// host_seq: sequences WRITE / READ / POLL commands into single-beat AXI-Lite transactions, one response per command.
// Build option: define HOST_SEQ_STATS_EN to add the stat_wr / stat_rd / stat_err traffic counters.
module host_seq #(
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    input  logic [7:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [63:0] M_AXI_WDATA,
    output logic [7:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [63:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
`ifdef HOST_SEQ_STATS_EN
    ,
    output logic [31:0] stat_wr,
    output logic [31:0] stat_rd,
    output logic [15:0] stat_err
`endif
);

    localparam logic [1:0]  OP_WR    = 2'd0;
    localparam logic [1:0]  OP_RD    = 2'd1;
    localparam logic [1:0]  OP_POLL  = 2'd2;
    localparam logic [1:0]  OP_RSV   = 2'd3;
    localparam logic [15:0] POLL_MAX = 16'(POLL_LIMIT);
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, GAP, RSP} state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        aw_done;
    logic        w_done;
    logic [15:0] poll_cnt;
    logic [15:0] gap_cnt;
    logic        accept;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        r_hs;
    logic        match;
    logic        poll_last;
    logic        poll_done;
    logic [1:0]  r_err;

    assign accept    = cmd_valid && cmd_ready;
    assign aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs      = M_AXI_BVALID && M_AXI_BREADY;
    assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;
    // The read being completed now is read number poll_cnt+1.
    assign poll_last = ({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_MAX};
    // Error and match outrank timeout, so a match on the final allowed read still succeeds.
    assign poll_done = (op_q != OP_POLL) || (M_AXI_RRESP != 2'd0) || match || poll_last;
    assign r_err     = (M_AXI_RRESP != 2'd0) ? 2'd1 :
                       (op_q == OP_POLL && !match && poll_last) ? 2'd2 : 2'd0;

    // Address and data come straight from the latched command, so they stay stable while VALID waits.
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

    // Masked compare of read data against the POLL match value; an empty mask always matches.
    always_comb begin
        match = 1'b1;
        for (int i = 0; i < 8; i++)
            if (wstrb_q[i] && (M_AXI_RDATA[8*i +: 8] != wdata_q[8*i +: 8]))
                match = 1'b0;
    end

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept)
                      state_nx = (cmd_op == OP_WR) ? WR : (cmd_op == OP_RSV) ? RSP : RA;
            WR:   if ((aw_done || aw_hs) && (w_done || w_hs))
                      state_nx = WB;
            WB:   if (M_AXI_BVALID)
                      state_nx = RSP;
            RA:   if (M_AXI_ARREADY)
                      state_nx = RD;
            RD:   if (M_AXI_RVALID)
                      state_nx = poll_done ? RSP : (POLL_GAP == 0) ? RA : GAP;
            GAP:  if (gap_cnt == GAP_LAST)
                      state_nx = RA;
            RSP:  if (rsp_ready)
                      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; reset forces IDLE, so every valid drops the moment reset asserts.
    always_comb begin
        cmd_ready     = aresetn && (state == IDLE);
        M_AXI_AWVALID = (state == WR) && !aw_done;
        M_AXI_WVALID  = (state == WR) && !w_done;
        M_AXI_BREADY  = (state == WB);
        M_AXI_ARVALID = (state == RA);
        M_AXI_RREADY  = (state == RD);
        rsp_valid     = (state == RSP);
    end

    // Capture the command on accept.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            op_q    <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 64'd0;
            wstrb_q <= 8'd0;
        end else if (accept) begin
            op_q    <= cmd_op;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    // Track AW and W handshakes independently so either may finish first.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (accept) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs)
                aw_done <= 1'b1;
            if (w_hs)
                w_done <= 1'b1;
        end
    end

    // Poll read counter (saturating) and inter-poll gap timer.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            poll_cnt <= 16'd0;
            gap_cnt  <= 16'd0;
        end else begin
            if (accept)
                poll_cnt <= 16'd0;
            else if (r_hs && poll_cnt != POLL_MAX)
                poll_cnt <= poll_cnt + 16'd1;
            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
        end
    end

    // Response data and error; a WRITE or reserved op reports zero data.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_data <= 64'd0;
            rsp_err  <= 2'd0;
        end else if (accept) begin
            rsp_data <= 64'd0;
            rsp_err  <= (cmd_op == OP_RSV) ? 2'd3 : 2'd0;
        end else if (b_hs) begin
            rsp_err  <= {1'b0, M_AXI_BRESP != 2'd0};
        end else if (r_hs) begin
            rsp_data <= M_AXI_RDATA;
            rsp_err  <= r_err;
        end
    end

`ifdef HOST_SEQ_STATS_EN
    // Free-running traffic counters, cleared only by reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_wr  <= 32'd0;
            stat_rd  <= 32'd0;
            stat_err <= 16'd0;
        end else begin
            if (b_hs)
                stat_wr <= stat_wr + 32'd1;
            if (r_hs)
                stat_rd <= stat_rd + 32'd1;
            if (rsp_valid && rsp_ready && rsp_err != 2'd0)
                stat_err <= stat_err + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_host_seq.sv
// tb_host_seq: directed checks of host_seq against a small AXI-Lite slave model with adjustable ready latency.
module tb_host_seq;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic [63:0] cmd_wdata = 64'd0;
    logic [7:0]  cmd_wstrb = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY = 1'b0;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'd0;
    logic        M_AXI_BVALID = 1'b0;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [63:0] M_AXI_RDATA = 64'd0;
    logic [1:0]  M_AXI_RRESP = 2'd0;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;

    int tests = 0;
    int fails = 0;

    // slave model state
    int          cyc = 0;
    int          aw_lat = 1;
    int          w_lat = 1;
    int          ar_lat = 1;
    logic [1:0]  bresp_cfg = 2'd0;
    logic [1:0]  rresp_cfg = 2'd0;
    logic [63:0] rq[$];
    int          ar_stamp[$];
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int          aw_k = 0, w_k = 0, ar_k = 0;
    logic        f_aw = 0, f_w = 0, f_b = 0, f_ar = 0, f_r = 0;
    logic        aw_seen = 0, w_seen = 0;

    always #5 clk = ~clk;

    host_seq #(.POLL_GAP(4), .POLL_LIMIT(3)) dut (
        .clk(clk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Slave: f_* flags mark handshakes that complete on the coming posedge; effects apply at the next negedge.
    always @(negedge clk) begin
        cyc++;
        if (!aresetn) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
            aw_k = 0; w_k = 0; ar_k = 0; aw_seen = 0; w_seen = 0;
            f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
        end else begin
            if (f_aw) begin n_aw++; aw_seen = 1; M_AXI_AWREADY = 0; aw_k = 0; end
            if (f_w) begin n_w++; w_seen = 1; M_AXI_WREADY = 0; w_k = 0; end
            if (f_b) begin n_b++; M_AXI_BVALID = 0; end
            if (f_r) begin n_r++; M_AXI_RVALID = 0; end
            if (f_ar) begin
                n_ar++; ar_stamp.push_back(cyc); M_AXI_ARREADY = 0; ar_k = 0;
                M_AXI_RVALID = 1; M_AXI_RRESP = rresp_cfg;
                if (rq.size() != 0) M_AXI_RDATA = rq.pop_front();
                else M_AXI_RDATA = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (aw_seen && w_seen) begin
                aw_seen = 0; w_seen = 0; M_AXI_BVALID = 1; M_AXI_BRESP = bresp_cfg;
            end
            if (M_AXI_AWVALID && !M_AXI_AWREADY) begin aw_k++; if (aw_k >= aw_lat) M_AXI_AWREADY = 1; end
            if (M_AXI_WVALID && !M_AXI_WREADY) begin w_k++; if (w_k >= w_lat) M_AXI_WREADY = 1; end
            if (M_AXI_ARVALID && !M_AXI_ARREADY) begin ar_k++; if (ar_k >= ar_lat) M_AXI_ARREADY = 1; end
            f_aw = M_AXI_AWVALID && M_AXI_AWREADY;
            f_w  = M_AXI_WVALID && M_AXI_WREADY;
            f_b  = M_AXI_BVALID && M_AXI_BREADY;
            f_ar = M_AXI_ARVALID && M_AXI_ARREADY;
            f_r  = M_AXI_RVALID && M_AXI_RREADY;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Present one command; returns in cycle 1 (the cycle after acceptance).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        tick;
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready); end
        cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        tick;
        cmd_valid = 0;
    endtask

    // Wait (bounded) for rsp_valid; n is the cycle index, counting the cycle after acceptance as 1.
    task automatic wait_rsp(input int start, output int n);
        n = start;
        while (!rsp_valid && n < 60) begin tick; n++; end
        tests++;
        if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles", rsp_valid, n); end
    endtask

    task automatic finish_rsp;
        rsp_ready = 1;
        tick;
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        tick; tick;
        tests++;
        if ({cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 7'd0) begin
            fails++; $display("FAIL reset_handshakes: got %b want 0000000",
                {cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY});
        end
        tests++;
        if (rsp_data !== 64'd0 || rsp_err !== 2'd0) begin
            fails++; $display("FAIL reset_rsp: data=%h err=%0d want 0/0", rsp_data, rsp_err);
        end
        aresetn = 1;
        tick;
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: cmd_ready=%b want 1", cmd_ready); end
    endtask

    task automatic test_write;
        int n;
        int b0;
        b0 = n_b;
        issue(2'd0, 32'h10, 64'h0123_4567_89AB_CDEF, 8'hFF);
        tests++;
        if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b11) begin
            fails++; $display("FAIL write_c1_valids: aw/w=%b want 11", {M_AXI_AWVALID, M_AXI_WVALID});
        end
        tests++;
        if (M_AXI_AWADDR !== 32'h10 || M_AXI_WDATA !== 64'h0123_4567_89AB_CDEF || M_AXI_WSTRB !== 8'hFF) begin
            fails++; $display("FAIL write_c1_payload: addr=%h data=%h strb=%h", M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB);
        end
        tick;
        tests++;
        if (rsp_valid !== 1'b0 || M_AXI_BREADY !== 1'b1) begin
            fails++; $display("FAIL write_c2: rsp_valid=%b bready=%b want 0/1", rsp_valid, M_AXI_BREADY);
        end
        wait_rsp(2, n);
        tests++;
        if (n !== 3) begin fails++; $display("FAIL write_latency: %0d cycles want 3", n); end
        tests++;
        if (rsp_err !== 2'd0 || rsp_data !== 64'd0) begin
            fails++; $display("FAIL write_rsp: err=%0d data=%h want 0/0", rsp_err, rsp_data);
        end
        tests++;
        if (n_b - b0 !== 1) begin fails++; $display("FAIL write_b_count: %0d want 1", n_b - b0); end
        finish_rsp;
    endtask

    task automatic test_aw_skew;
        int n;
        int aw_c = 0, w_c = 0, addr_bad = 0, b0;
        b0 = n_b;
        aw_lat = 5;
        issue(2'd0, 32'h44, 64'h1111_2222_3333_4444, 8'h0F);
        n = 1;
        while (!rsp_valid && n < 40) begin
            if (M_AXI_AWVALID) begin aw_c++; if (M_AXI_AWADDR !== 32'h44) addr_bad++; end
            if (M_AXI_WVALID) w_c++;
            tick;
            n++;
        end
        aw_lat = 1;
        tests++;
        if (w_c !== 1) begin fails++; $display("FAIL skew_wvalid_cycles: %0d want 1", w_c); end
        tests++;
        if (aw_c !== 5) begin fails++; $display("FAIL skew_awvalid_cycles: %0d want 5", aw_c); end
        tests++;
        if (addr_bad !== 0) begin fails++; $display("FAIL skew_addr_stable: %0d unstable cycles want 0", addr_bad); end
        tests++;
        if (rsp_valid !== 1'b1 || n !== 7) begin fails++; $display("FAIL skew_latency: valid=%b at %0d want 1 at 7", rsp_valid, n); end
        tests++;
        if (rsp_err !== 2'd0 || n_b - b0 !== 1) begin
            fails++; $display("FAIL skew_rsp: err=%0d b_count=%0d want 0/1", rsp_err, n_b - b0);
        end
        finish_rsp;
    endtask

    task automatic test_write_err;
        int n;
        bresp_cfg = 2'd3;
        issue(2'd0, 32'h18, 64'hFFFF, 8'h03);
        wait_rsp(1, n);
        bresp_cfg = 2'd0;
        tests++;
        if (n !== 3 || rsp_err !== 2'd1 || rsp_data !== 64'd0) begin
            fails++; $display("FAIL write_bresp: cycle=%0d err=%0d data=%h want 3/1/0", n, rsp_err, rsp_data);
        end
        finish_rsp;
    endtask

    task automatic test_read_err;
        int n;
        rresp_cfg = 2'd2;
        rq.push_back(64'hDEAD);
        issue(2'd1, 32'h20, 64'd0, 8'd0);
        tests++;
        if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h20) begin
            fails++; $display("FAIL read_c1: arvalid=%b araddr=%h want 1/20", M_AXI_ARVALID, M_AXI_ARADDR);
        end
        wait_rsp(1, n);
        rresp_cfg = 2'd0;
        tests++;
        if (n !== 3) begin fails++; $display("FAIL read_latency: %0d cycles want 3", n); end
        tests++;
        if (rsp_data !== 64'hDEAD || rsp_err !== 2'd1) begin
            fails++; $display("FAIL read_rresp: data=%h err=%0d want dead/1", rsp_data, rsp_err);
        end
        finish_rsp;
    endtask

    // Third read matches exactly when the poll limit (3) is reached: match must win over timeout.
    task automatic test_poll_match;
        int n;
        int s0, r0;
        s0 = ar_stamp.size();
        r0 = n_r;
        rq.push_back(64'h1); rq.push_back(64'h1); rq.push_back(64'hAB00);
        issue(2'd2, 32'h30, 64'h0, 8'h01);
        wait_rsp(1, n);
        tests++;
        if (n_r - r0 !== 3 || ar_stamp.size() - s0 !== 3) begin
            fails++; $display("FAIL poll_match_reads: r=%0d ar=%0d want 3/3", n_r - r0, ar_stamp.size() - s0);
        end else begin
            tests++;
            if (ar_stamp[s0+1] - ar_stamp[s0] !== 6 || ar_stamp[s0+2] - ar_stamp[s0+1] !== 6) begin
                fails++; $display("FAIL poll_gap_spacing: %0d,%0d want 6,6",
                    ar_stamp[s0+1] - ar_stamp[s0], ar_stamp[s0+2] - ar_stamp[s0+1]);
            end
        end
        tests++;
        if (n !== 15) begin fails++; $display("FAIL poll_match_latency: %0d cycles want 15", n); end
        tests++;
        if (rsp_err !== 2'd0 || rsp_data !== 64'hAB00) begin
            fails++; $display("FAIL poll_match_rsp: err=%0d data=%h want 0/ab00", rsp_err, rsp_data);
        end
        finish_rsp;
    endtask

    task automatic test_poll_timeout;
        int n;
        int r0;
        r0 = n_r;
        rq.push_back(64'hFF00_0000_0000_0001); rq.push_back(64'hFF00_0000_0000_0001); rq.push_back(64'hFF00_0000_0000_0001);
        issue(2'd2, 32'h30, 64'hFF00_0000_0000_0000, 8'h01);
        wait_rsp(1, n);
        tests++;
        if (n !== 15 || rsp_err !== 2'd2 || rsp_data !== 64'hFF00_0000_0000_0001) begin
            fails++; $display("FAIL poll_timeout_rsp: cycle=%0d err=%0d data=%h want 15/2/ff00000000000001", n, rsp_err, rsp_data);
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            tests++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_err !== 2'd2 || rsp_data !== 64'hFF00_0000_0000_0001) begin
                fails++; $display("FAIL poll_backpressure[%0d]: valid=%b ready=%b err=%0d data=%h want 1/0/2/ff00000000000001",
                    i, rsp_valid, cmd_ready, rsp_err, rsp_data);
            end
        end
        tests++;
        if (n_r - r0 !== 3) begin fails++; $display("FAIL poll_timeout_reads: %0d want 3", n_r - r0); end
        finish_rsp;
    endtask

    task automatic test_reserved;
        int n;
        int bus0;
        bus0 = n_aw + n_w + n_ar;
        issue(2'd3, 32'h99, 64'h1234, 8'hFF);
        wait_rsp(1, n);
        tests++;
        if (n !== 1 || rsp_err !== 2'd3 || rsp_data !== 64'd0) begin
            fails++; $display("FAIL reserved_rsp: cycle=%0d err=%0d data=%h want 1/3/0", n, rsp_err, rsp_data);
        end
        finish_rsp;
        tick;
        tests++;
        if (n_aw + n_w + n_ar - bus0 !== 0) begin fails++; $display("FAIL reserved_bus: %0d handshakes want 0", n_aw + n_w + n_ar - bus0); end
    endtask

    task automatic test_reset_mid_wr;
        int n;
        aw_lat = 50;
        issue(2'd0, 32'h60, 64'h55, 8'h01);
        tick;
        tests++;
        if (M_AXI_AWVALID !== 1'b1) begin fails++; $display("FAIL midwr_awvalid: %b want 1", M_AXI_AWVALID); end
        aresetn = 0;
        #1;
        tests++;
        if ({cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 7'd0) begin
            fails++; $display("FAIL midwr_reset_drop: got %b want 0000000",
                {cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY});
        end
        aw_lat = 1;
        tick; tick;
        aresetn = 1;
        tick;
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL midwr_release_ready: %b want 1", cmd_ready); end
        rq.push_back(64'h5A5A_0000_1234_5678);
        issue(2'd1, 32'h80, 64'd0, 8'd0);
        wait_rsp(1, n);
        tests++;
        if (n !== 3 || rsp_err !== 2'd0 || rsp_data !== 64'h5A5A_0000_1234_5678) begin
            fails++; $display("FAIL midwr_read_after: cycle=%0d err=%0d data=%h want 3/0/5a5a000012345678", n, rsp_err, rsp_data);
        end
        finish_rsp;
    endtask

    initial begin
        test_reset;
        test_write;
        test_aw_skew;
        test_write_err;
        test_read_err;
        test_poll_match;
        test_poll_timeout;
        test_reserved;
        test_reset_mid_wr;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
